// File: rtl/uart_work_rx.sv
// Frames the uart receive byte stream (SOF, payload, XOR checksum) into one wide work word.
// Framing errors, checksum mismatches and inter-byte timeouts abort the frame and are flagged.
module uart_work_rx #(
   parameter int unsigned WORK_BYTES     = 44,
   parameter logic [7:0]  SOF            = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   input  logic                    rx_frame_err,
   output logic [WORK_BYTES*8-1:0] work_data,
   output logic                    work_valid,
   output logic                    crc_err,
   output logic                    timeout_err,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int unsigned W     = WORK_BYTES * 8;
   localparam int unsigned CNT_W = (WORK_BYTES > 1) ? $clog2(WORK_BYTES) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       acc_q;
   logic [TMO_W-1:0] tmo_q;
   logic [W-1:0]     shadow_q;
   logic [W-1:0]     work_data_q;
   logic             work_valid_q;
   logic             crc_err_q;
   logic             timeout_err_q;
   logic             frame_err_q;
   logic             busy_q;

   logic [W-1:0]     shadow_d;
   logic [7:0]       acc_d;
   logic [TMO_W-1:0] tmo_d;
   logic             tmo_hit_s;

   // Next values of the datapath registers for an accepted byte or an idle cycle.
   always_comb begin
      shadow_d  = (shadow_q << 4'd8) | W'(rx_data);
      acc_d     = acc_q ^ rx_data;
      tmo_d     = tmo_q + TMO_W'(1);
      tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   end

   // Frame FSM; a byte strobe clears the timeout, so a byte on the limit cycle wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         acc_q         <= 8'h00;
         tmo_q         <= '0;
         shadow_q      <= '0;
         work_data_q   <= '0;
         work_valid_q  <= 1'b0;
         crc_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         work_valid_q  <= 1'b0;
         crc_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_err_q   <= rx_frame_err;
         case (state_q)
            IDLE: begin
               tmo_q <= '0;
               if (rx_valid && !rx_frame_err && (rx_data == SOF)) begin
                  state_q <= RECV;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  acc_q   <= 8'h00;
               end
            end
            RECV: begin
               if (rx_frame_err) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  tmo_q   <= '0;
               end else if (rx_valid) begin
                  shadow_q <= shadow_d;
                  acc_q    <= acc_d;
                  cnt_q    <= cnt_q + CNT_W'(1);
                  tmo_q    <= '0;
                  if (cnt_q == CNT_W'(WORK_BYTES - 1)) begin
                     state_q <= CHECK;
                  end
               end else if (tmo_hit_s) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= IDLE;
                  busy_q        <= 1'b0;
                  tmo_q         <= '0;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            CHECK: begin
               if (rx_frame_err) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  tmo_q   <= '0;
               end else if (rx_valid) begin
                  if (rx_data == acc_q) begin
                     work_data_q  <= shadow_q;
                     work_valid_q <= 1'b1;
                  end else begin
                     crc_err_q <= 1'b1;
                  end
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  tmo_q   <= '0;
               end else if (tmo_hit_s) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= IDLE;
                  busy_q        <= 1'b0;
                  tmo_q         <= '0;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               tmo_q   <= '0;
            end
         endcase
      end
   end

   assign work_data   = work_data_q;
   assign work_valid  = work_valid_q;
   assign crc_err     = crc_err_q;
   assign timeout_err = timeout_err_q;
   assign frame_err   = frame_err_q;
   assign busy        = busy_q;

endmodule
